// File: rtl/decode_cycle_if.sv
// Fetch/writeback to ID/EX signal bundle for the decode stage.
// The master side drives the instruction and writeback; the slave (decode) drives the ID/EX outputs.
interface decode_cycle_if #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
);
  logic [31:0]       InstrD;
  logic [31:0]       PCD;
  logic [31:0]       PCPlus4D;
  logic              RegWriteW;
  logic [REG_AW-1:0] RDW;
  logic [DATA_W-1:0] ResultW;
  logic              FlushE;

  logic              RegWriteE;
  logic [1:0]        ResultSrcE;
  logic              MemWriteE;
  logic              JumpE;
  logic              BranchE;
  logic [2:0]        ALUControlE;
  logic              ALUSrcE;
  logic [DATA_W-1:0] RD1E;
  logic [DATA_W-1:0] RD2E;
  logic [DATA_W-1:0] ImmExtE;
  logic [REG_AW-1:0] RdE;
  logic [REG_AW-1:0] Rs1E;
  logic [REG_AW-1:0] Rs2E;
  logic [31:0]       PCE;
  logic [31:0]       PCPlus4E;

  modport master (
    output InstrD, PCD, PCPlus4D, RegWriteW, RDW, ResultW, FlushE,
    input  RegWriteE, ResultSrcE, MemWriteE, JumpE, BranchE, ALUControlE, ALUSrcE,
    input  RD1E, RD2E, ImmExtE, RdE, Rs1E, Rs2E, PCE, PCPlus4E
  );

  modport slave (
    input  InstrD, PCD, PCPlus4D, RegWriteW, RDW, ResultW, FlushE,
    output RegWriteE, ResultSrcE, MemWriteE, JumpE, BranchE, ALUControlE, ALUSrcE,
    output RD1E, RD2E, ImmExtE, RdE, Rs1E, Rs2E, PCE, PCPlus4E
  );
endinterface

// File: rtl/decode_cycle.sv
// RV32I ID stage: combinational decode, 2R1W register file with write-through,
// immediate sign-extension and the ID/EX pipeline register.
module decode_cycle #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
) (
  input  logic           clk,
  input  logic           rst,
  decode_cycle_if.slave  id
);

  localparam int NREG = 1 << REG_AW;

  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_BEQ  = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  typedef enum logic [1:0] {IMM_I, IMM_S, IMM_B, IMM_J} imm_sel_e;

  // Returns {supported, alu_op} for the shared R/I-type funct3 map.
  function automatic logic [3:0] alu_decode(input logic [2:0] f3, input logic sub);
    case (f3)
      3'b000:  alu_decode = {1'b1, (sub ? ALU_SUB : ALU_ADD)};
      3'b010:  alu_decode = {1'b1, ALU_SLT};
      3'b110:  alu_decode = {1'b1, ALU_OR};
      3'b111:  alu_decode = {1'b1, ALU_AND};
      default: alu_decode = 4'b0000;
    endcase
  endfunction

  function automatic logic signed [DATA_W-1:0] imm_ext(input logic [31:0] ins, input imm_sel_e sel);
    case (sel)
      IMM_S:   imm_ext = {{(DATA_W-12){ins[31]}}, ins[31:25], ins[11:7]};
      IMM_B:   imm_ext = {{(DATA_W-13){ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
      IMM_J:   imm_ext = {{(DATA_W-21){ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
      default: imm_ext = {{(DATA_W-12){ins[31]}}, ins[31:20]};
    endcase
  endfunction

  logic [6:0]        opcode;
  logic [2:0]        funct3;
  logic [REG_AW-1:0] rs1, rs2, rd;

  assign opcode = id.InstrD[6:0];
  assign funct3 = id.InstrD[14:12];
  assign rd     = id.InstrD[11:7];
  assign rs1    = id.InstrD[19:15];
  assign rs2    = id.InstrD[24:20];

  logic              reg_write_d, mem_write_d, jump_d, branch_d, alu_src_d;
  logic [1:0]        result_src_d;
  logic [2:0]        alu_ctrl_d;
  imm_sel_e          imm_sel;
  logic [3:0]        alu_dec;

  always_comb begin
    reg_write_d  = 1'b0;
    result_src_d = 2'b00;
    mem_write_d  = 1'b0;
    jump_d       = 1'b0;
    branch_d     = 1'b0;
    alu_ctrl_d   = ALU_ADD;
    alu_src_d    = 1'b0;
    imm_sel      = IMM_I;
    alu_dec      = 4'b0000;
    case (opcode)
      OP_LW: if (funct3 == 3'b010) begin
        reg_write_d  = 1'b1;
        result_src_d = 2'b01;
        alu_src_d    = 1'b1;
      end
      OP_SW: begin
        imm_sel = IMM_S;
        if (funct3 == 3'b010) begin
          mem_write_d = 1'b1;
          alu_src_d   = 1'b1;
        end
      end
      OP_R: begin
        alu_dec = alu_decode(funct3, id.InstrD[30]);
        if (alu_dec[3]) begin
          reg_write_d = 1'b1;
          alu_ctrl_d  = alu_dec[2:0];
        end
      end
      // funct7 carries immediate bits here, so funct3 000 is always add.
      OP_I: begin
        alu_dec = alu_decode(funct3, 1'b0);
        if (alu_dec[3]) begin
          reg_write_d = 1'b1;
          alu_src_d   = 1'b1;
          alu_ctrl_d  = alu_dec[2:0];
        end
      end
      OP_BEQ: begin
        imm_sel = IMM_B;
        if (funct3 == 3'b000) begin
          branch_d   = 1'b1;
          alu_ctrl_d = ALU_SUB;
        end
      end
      OP_JAL: begin
        imm_sel      = IMM_J;
        jump_d       = 1'b1;
        reg_write_d  = 1'b1;
        result_src_d = 2'b10;
      end
      default: ;
    endcase
  end

  logic [DATA_W-1:0] rf_q [1:NREG-1];
  logic              wr_en;
  logic [DATA_W-1:0] rd1_d, rd2_d;
  logic signed [DATA_W-1:0] imm_d;

  assign wr_en = id.RegWriteW && (id.RDW != '0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 1; i < NREG; i++) rf_q[i] <= '0;
    end else if (wr_en) begin
      rf_q[id.RDW] <= id.ResultW;
    end
  end

  // Write-through: a same-cycle writeback to a source register wins over the stored value.
  always_comb begin
    rd1_d = '0;
    rd2_d = '0;
    if (rs1 != '0) rd1_d = (wr_en && id.RDW == rs1) ? id.ResultW : rf_q[rs1];
    if (rs2 != '0) rd2_d = (wr_en && id.RDW == rs2) ? id.ResultW : rf_q[rs2];
  end

  assign imm_d = imm_ext(id.InstrD, imm_sel);

  // ---- ID/EX boundary ----
  logic              reg_write_q, mem_write_q, jump_q, branch_q, alu_src_q;
  logic [1:0]        result_src_q;
  logic [2:0]        alu_ctrl_q;
  logic [DATA_W-1:0] rd1_q, rd2_q, imm_q;
  logic [REG_AW-1:0] rd_q, rs1_q, rs2_q;
  logic [31:0]       pc_q, pc4_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      reg_write_q  <= 1'b0;
      result_src_q <= 2'b00;
      mem_write_q  <= 1'b0;
      jump_q       <= 1'b0;
      branch_q     <= 1'b0;
      alu_ctrl_q   <= 3'b000;
      alu_src_q    <= 1'b0;
      rd_q         <= '0;
      rd1_q        <= '0;
      rd2_q        <= '0;
      imm_q        <= '0;
      rs1_q        <= '0;
      rs2_q        <= '0;
      pc_q         <= '0;
      pc4_q        <= '0;
    end else begin
      reg_write_q  <= id.FlushE ? 1'b0   : reg_write_d;
      result_src_q <= id.FlushE ? 2'b00  : result_src_d;
      mem_write_q  <= id.FlushE ? 1'b0   : mem_write_d;
      jump_q       <= id.FlushE ? 1'b0   : jump_d;
      branch_q     <= id.FlushE ? 1'b0   : branch_d;
      alu_ctrl_q   <= id.FlushE ? 3'b000 : alu_ctrl_d;
      alu_src_q    <= id.FlushE ? 1'b0   : alu_src_d;
      rd_q         <= id.FlushE ? '0     : rd;
      rd1_q        <= rd1_d;
      rd2_q        <= rd2_d;
      imm_q        <= imm_d;
      rs1_q        <= rs1;
      rs2_q        <= rs2;
      pc_q         <= id.PCD;
      pc4_q        <= id.PCPlus4D;
    end
  end

  assign id.RegWriteE   = reg_write_q;
  assign id.ResultSrcE  = result_src_q;
  assign id.MemWriteE   = mem_write_q;
  assign id.JumpE       = jump_q;
  assign id.BranchE     = branch_q;
  assign id.ALUControlE = alu_ctrl_q;
  assign id.ALUSrcE     = alu_src_q;
  assign id.RD1E        = rd1_q;
  assign id.RD2E        = rd2_q;
  assign id.ImmExtE     = imm_q;
  assign id.RdE         = rd_q;
  assign id.Rs1E        = rs1_q;
  assign id.Rs2E        = rs2_q;
  assign id.PCE         = pc_q;
  assign id.PCPlus4E    = pc4_q;

endmodule

// File: tb/tb_decode_cycle.sv
// Directed-vector bench for decode_cycle: the stimulus process queues hand-computed
// ID/EX expectations, a monitor pops one per rising edge and compares every output.
module tb_decode_cycle;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  decode_cycle_if #(.DATA_W(32), .REG_AW(5)) bus ();
  decode_cycle #(.DATA_W(32), .REG_AW(5)) dut (.clk(clk), .rst(rst), .id(bus));

  typedef struct {
    logic [9:0]  ctrl;   // {RegWrite, ResultSrc[1:0], MemWrite, Jump, Branch, ALUControl[2:0], ALUSrc}
    logic [31:0] rd1, rd2, imm;
    logic [4:0]  rd, rs1, rs2;
    logic [31:0] pc, pc4;
    int          idx;
  } exp_t;

  exp_t q[$];
  int   vectors = 0;
  int   miscompares = 0;
  int   issued = 0;

  localparam logic [9:0] C_NOP  = 10'b0_00_0_0_0_000_0;
  localparam logic [9:0] C_ADDI = 10'b1_00_0_0_0_000_1;
  localparam logic [9:0] C_ADD  = 10'b1_00_0_0_0_000_0;
  localparam logic [9:0] C_SW   = 10'b0_00_1_0_0_000_1;
  localparam logic [9:0] C_BEQ  = 10'b0_00_0_0_1_001_0;
  localparam logic [9:0] C_JAL  = 10'b1_10_0_1_0_000_0;
  localparam logic [9:0] C_OR   = 10'b1_00_0_0_0_011_0;
  localparam logic [9:0] C_SUB  = 10'b1_00_0_0_0_001_0;
  localparam logic [9:0] C_AND  = 10'b1_00_0_0_0_010_0;
  localparam logic [9:0] C_SLTI = 10'b1_00_0_0_0_101_1;
  localparam logic [9:0] C_LW   = 10'b1_01_0_0_0_000_1;

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    if (act !== exp) begin
      miscompares++;
      $display("FAIL vec%0d %s: got 0x%08h expected 0x%08h", idx, name, act, exp);
    end
  endtask

  // Drive one instruction plus writeback, queue its expectation, then wait for the next falling edge.
  task automatic issue(input logic [31:0] instr, input logic [31:0] pc, input logic wen,
                       input logic [4:0] rdw, input logic [31:0] resw, input logic flush,
                       input logic [9:0] ctrl, input logic [31:0] rd1, input logic [31:0] rd2,
                       input logic [31:0] imm, input logic [4:0] rd, input logic [4:0] rs1,
                       input logic [4:0] rs2, input logic zero_pc);
    exp_t e;
    bus.InstrD    = instr;
    bus.PCD       = pc;
    bus.PCPlus4D  = pc + 32'd4;
    bus.RegWriteW = wen;
    bus.RDW       = rdw;
    bus.ResultW   = resw;
    bus.FlushE    = flush;
    e.ctrl = ctrl; e.rd1 = rd1; e.rd2 = rd2; e.imm = imm;
    e.rd = rd; e.rs1 = rs1; e.rs2 = rs2;
    e.pc  = zero_pc ? 32'd0 : pc;
    e.pc4 = zero_pc ? 32'd0 : pc + 32'd4;
    e.idx = issued;
    issued++;
    q.push_back(e);
    @(negedge clk);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        vectors++;
        chk("RegWriteE",   e.idx, {31'd0, bus.RegWriteE},   {31'd0, e.ctrl[9]});
        chk("ResultSrcE",  e.idx, {30'd0, bus.ResultSrcE},  {30'd0, e.ctrl[8:7]});
        chk("MemWriteE",   e.idx, {31'd0, bus.MemWriteE},   {31'd0, e.ctrl[6]});
        chk("JumpE",       e.idx, {31'd0, bus.JumpE},       {31'd0, e.ctrl[5]});
        chk("BranchE",     e.idx, {31'd0, bus.BranchE},     {31'd0, e.ctrl[4]});
        chk("ALUControlE", e.idx, {29'd0, bus.ALUControlE}, {29'd0, e.ctrl[3:1]});
        chk("ALUSrcE",     e.idx, {31'd0, bus.ALUSrcE},     {31'd0, e.ctrl[0]});
        chk("RD1E",        e.idx, bus.RD1E,    e.rd1);
        chk("RD2E",        e.idx, bus.RD2E,    e.rd2);
        chk("ImmExtE",     e.idx, bus.ImmExtE, e.imm);
        chk("RdE",         e.idx, {27'd0, bus.RdE},  {27'd0, e.rd});
        chk("Rs1E",        e.idx, {27'd0, bus.Rs1E}, {27'd0, e.rs1});
        chk("Rs2E",        e.idx, {27'd0, bus.Rs2E}, {27'd0, e.rs2});
        chk("PCE",         e.idx, bus.PCE,      e.pc);
        chk("PCPlus4E",    e.idx, bus.PCPlus4E, e.pc4);
      end
    end
  end

  initial begin : stimulus
    int guard;
    //    instr         pc         wen  rdw    resw          fl    ctrl    rd1           rd2           imm           rd     rs1    rs2   zpc
    // Reset held; a writeback to x5 during reset must be lost.
    issue(32'h00500093, 32'h00, 1'b1, 5'd5,  32'h00000055, 1'b0, C_NOP,  32'h0,        32'h0,        32'h0,        5'd0,  5'd0,  5'd0,  1'b1);
    issue(32'h00500093, 32'h00, 1'b1, 5'd5,  32'h00000055, 1'b0, C_NOP,  32'h0,        32'h0,        32'h0,        5'd0,  5'd0,  5'd0,  1'b1);
    rst = 1'b1;
    // addi x1,x0,5 (rs2 field = 5 reads the cleared x5)
    issue(32'h00500093, 32'h00, 1'b0, 5'd0,  32'h0,        1'b0, C_ADDI, 32'h0,        32'h0,        32'h5,        5'd1,  5'd0,  5'd5,  1'b0);
    // add x0,x0,x0 while writing x1=0x100
    issue(32'h00000033, 32'h04, 1'b1, 5'd1,  32'h00000100, 1'b0, C_ADD,  32'h0,        32'h0,        32'h0,        5'd0,  5'd0,  5'd0,  1'b0);
    // sw x2,8(x1)
    issue(32'h0020A423, 32'h08, 1'b0, 5'd0,  32'h0,        1'b0, C_SW,   32'h100,      32'h0,        32'h8,        5'd8,  5'd1,  5'd2,  1'b0);
    // beq x0,x0,-4
    issue(32'hFE000EE3, 32'h20, 1'b0, 5'd0,  32'h0,        1'b0, C_BEQ,  32'h0,        32'h0,        32'hFFFFFFFC, 5'd29, 5'd0,  5'd0,  1'b0);
    // add x4,x3,x0 with same-cycle write of x3
    issue(32'h00018233, 32'h24, 1'b1, 5'd3,  32'hDEADBEEF, 1'b0, C_ADD,  32'hDEADBEEF, 32'h0,        32'h0,        5'd4,  5'd3,  5'd0,  1'b0);
    issue(32'h00018233, 32'h28, 1'b0, 5'd0,  32'h0,        1'b0, C_ADD,  32'hDEADBEEF, 32'h0,        32'h0,        5'd4,  5'd3,  5'd0,  1'b0);
    // x0 write attempt, then read back
    issue(32'h00000033, 32'h2C, 1'b1, 5'd0,  32'h00001234, 1'b0, C_ADD,  32'h0,        32'h0,        32'h0,        5'd0,  5'd0,  5'd0,  1'b0);
    issue(32'h00000033, 32'h30, 1'b0, 5'd0,  32'h0,        1'b0, C_ADD,  32'h0,        32'h0,        32'h0,        5'd0,  5'd0,  5'd0,  1'b0);
    // jal x1,8 flushed, with independent writeback x6=0x66
    issue(32'h008000EF, 32'h34, 1'b1, 5'd6,  32'h00000066, 1'b1, C_NOP,  32'h0,        32'h0,        32'h8,        5'd0,  5'd0,  5'd8,  1'b0);
    issue(32'h008000EF, 32'h38, 1'b0, 5'd0,  32'h0,        1'b0, C_JAL,  32'h0,        32'h0,        32'h8,        5'd1,  5'd0,  5'd8,  1'b0);
    // unsupported opcode
    issue(32'hFFFFFFFF, 32'h3C, 1'b0, 5'd0,  32'h0,        1'b0, C_NOP,  32'h0,        32'h0,        32'hFFFFFFFF, 5'd31, 5'd31, 5'd31, 1'b0);
    // or x7,x6,x1 ; sub x8,x1,x6 ; and x13,x1,x6
    issue(32'h001363B3, 32'h40, 1'b0, 5'd0,  32'h0,        1'b0, C_OR,   32'h66,       32'h100,      32'h1,        5'd7,  5'd6,  5'd1,  1'b0);
    issue(32'h40608433, 32'h44, 1'b0, 5'd0,  32'h0,        1'b0, C_SUB,  32'h100,      32'h66,       32'h406,      5'd8,  5'd1,  5'd6,  1'b0);
    issue(32'h0060F6B3, 32'h48, 1'b0, 5'd0,  32'h0,        1'b0, C_AND,  32'h100,      32'h66,       32'h6,        5'd13, 5'd1,  5'd6,  1'b0);
    // slti x9,x1,-1 ; addi x10,x0,-1024 (bit30 set, still add) ; lw x11,4(x1)
    issue(32'hFFF0A493, 32'h4C, 1'b0, 5'd0,  32'h0,        1'b0, C_SLTI, 32'h100,      32'h0,        32'hFFFFFFFF, 5'd9,  5'd1,  5'd31, 1'b0);
    issue(32'hC0000513, 32'h50, 1'b0, 5'd0,  32'h0,        1'b0, C_ADDI, 32'h0,        32'h0,        32'hFFFFFC00, 5'd10, 5'd0,  5'd0,  1'b0);
    issue(32'h0040A583, 32'h54, 1'b0, 5'd0,  32'h0,        1'b0, C_LW,   32'h100,      32'h0,        32'h4,        5'd11, 5'd1,  5'd4,  1'b0);
    // sll (unsupported funct3)
    issue(32'h00609633, 32'h58, 1'b0, 5'd0,  32'h0,        1'b0, C_NOP,  32'h100,      32'h66,       32'h6,        5'd12, 5'd1,  5'd6,  1'b0);
    // reset mid-stream during a write: write lost, file cleared
    rst = 1'b0;
    issue(32'h001363B3, 32'h5C, 1'b1, 5'd1,  32'h00000BAD, 1'b0, C_NOP,  32'h0,        32'h0,        32'h0,        5'd0,  5'd0,  5'd0,  1'b1);
    rst = 1'b1;
    issue(32'h001363B3, 32'h60, 1'b0, 5'd0,  32'h0,        1'b0, C_OR,   32'h0,        32'h0,        32'h1,        5'd7,  5'd6,  5'd1,  1'b0);

    guard = 0;
    while (q.size() > 0 && guard < 10) begin
      @(negedge clk);
      guard++;
    end
    if (q.size() > 0) begin
      miscompares++;
      $display("FAIL drain: %0d expectations still pending, required 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
